// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues requests to a synchronous
// instruction memory and buffers returned words in a small queue ahead of decode.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2,
  parameter logic [31:0]     NOP      = 32'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] pc_current_r,
  output logic            misalign
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic            inflight, infl_epoch, epoch;
  logic [XLEN-1:0] infl_pc;
  logic            misalign_r;
  logic            empty, full, push, pop, credit;

  // Decode handshake: a transfer happens on a cycle where id_valid && id_ready;
  // while id_valid && !id_ready the head (id_instr/id_pc) is held unchanged, and
  // id_valid never depends on id_ready.
  always_comb begin
    empty     = (count == '0);
    full      = (count == CW'(DEPTH));
    id_valid  = !empty && !redirect_valid;
    pop       = id_valid && id_ready;
    // A return is kept only if no redirect happened since it was issued.
    push      = inflight && (infl_epoch == epoch) && !redirect_valid;
    occupancy = (CW + 1)'(count) + (CW + 1)'(inflight);
    credit    = (occupancy < (CW + 1)'(DEPTH)) || pop;
    imem_req  = !rst && !redirect_valid && credit;
    imem_addr = pc_current_r;
    id_instr  = id_valid ? q_instr[head] : NOP;
    id_pc     = id_valid ? q_pc[head] : '0;
    misalign  = misalign_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_current_r <= RESET_PC;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      infl_epoch   <= 1'b0;
      infl_pc      <= '0;
      epoch        <= 1'b0;
      misalign_r   <= 1'b0;
    end else begin
      misalign_r <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      inflight   <= imem_req;
      if (imem_req) begin
        infl_pc    <= pc_current_r;
        infl_epoch <= epoch;
      end
      if (redirect_valid) begin
        head         <= '0;
        tail         <= '0;
        count        <= '0;
        epoch        <= ~epoch;
        pc_current_r <= {redirect_pc[XLEN-1:2], 2'b00};
      end else begin
        if (imem_req) pc_current_r <= pc_current_r + XLEN'(4);
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= infl_pc;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for the wrap-around reset PC and asynchronous mid-stream reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req, id_valid, id_ready, misalign;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc, pc_current_r;

  logic        imem_req2, id_valid2, misalign2;
  logic [31:0] imem_addr2, imem_rdata2, id_instr2, id_pc2, pc_current_r2;

  localparam logic [31:0] NOP = 32'h13;
  localparam logic [31:0] RESET_PC2 = 32'hFFFF_FFF8;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .pc_current_r(pc_current_r), .misalign(misalign)
  );

  fetch_unit #(.RESET_PC(RESET_PC2)) dut2 (
    .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .id_valid(id_valid2), .id_ready(1'b1), .id_instr(id_instr2), .id_pc(id_pc2),
    .pc_current_r(pc_current_r2), .misalign(misalign2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  // Synchronous instruction memories: data valid the cycle after the request.
  always @(posedge clk) begin
    if (imem_req)  imem_rdata  <= mem_word(imem_addr);
    if (imem_req2) imem_rdata2 <= mem_word(imem_addr2);
  end

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic        mis;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic req, input logic [31:0] addr, input logic valid,
                     input logic [31:0] pc, input logic mis);
    vec_t v;
    v = '{rv, rpc, rdy, req, addr, valid, pc, mis};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst pc_current_r", pc_current_r, 32'h0);
    chk("rst imem_req", 32'(imem_req), 32'h0);
    chk("rst id_valid", 32'(id_valid), 32'h0);
    chk("rst id_instr", id_instr, NOP);
    chk("rst id_pc", id_pc, 32'h0);
    chk("rst misalign", 32'(misalign), 32'h0);
    chk("rst dut2 pc_current_r", pc_current_r2, RESET_PC2);

    // rv, rpc, rdy | req, addr, valid, id_pc, misalign
    add(0, 32'h0,   1, 1, 32'h00,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h04,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h08,  1, 32'h00,  0);
    add(0, 32'h0,   1, 1, 32'h0C,  1, 32'h04,  0);
    add(0, 32'h0,   0, 0, 32'h10,  1, 32'h08,  0);
    add(0, 32'h0,   0, 0, 32'h10,  1, 32'h08,  0);
    add(0, 32'h0,   0, 0, 32'h10,  1, 32'h08,  0);
    add(0, 32'h0,   0, 0, 32'h10,  1, 32'h08,  0);
    add(0, 32'h0,   0, 0, 32'h10,  1, 32'h08,  0);
    add(0, 32'h0,   1, 1, 32'h10,  1, 32'h08,  0);
    add(0, 32'h0,   1, 1, 32'h14,  1, 32'h0C,  0);
    add(0, 32'h0,   1, 1, 32'h18,  1, 32'h10,  0);
    add(1, 32'h40,  1, 0, 32'h1C,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h40,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h44,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h48,  1, 32'h40,  0);
    add(0, 32'h0,   1, 1, 32'h4C,  1, 32'h44,  0);
    add(1, 32'h83,  1, 0, 32'h50,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h80,  0, 32'h0,   1);
    add(0, 32'h0,   1, 1, 32'h84,  0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h88,  1, 32'h80,  0);
    add(0, 32'h0,   1, 1, 32'h8C,  1, 32'h84,  0);
    add(1, 32'h100, 1, 0, 32'h90,  0, 32'h0,   0);
    add(1, 32'h202, 1, 0, 32'h100, 0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   1);
    add(0, 32'h0,   1, 1, 32'h204, 0, 32'h0,   0);
    add(0, 32'h0,   1, 1, 32'h208, 1, 32'h200, 0);

    // Second instance starts near the top of the address space and must wrap.
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);

    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < vq.size(); k++) begin
      if (k != 0) next_cycle();
      redirect_valid = vq[k].rv;
      redirect_pc    = vq[k].rpc;
      id_ready       = vq[k].rdy;
      @(negedge clk);
      chk($sformatf("v%0d imem_req", k), 32'(imem_req), 32'(vq[k].req));
      chk($sformatf("v%0d imem_addr", k), imem_addr, vq[k].addr);
      chk($sformatf("v%0d pc_current_r", k), pc_current_r, vq[k].addr);
      chk($sformatf("v%0d id_valid", k), 32'(id_valid), 32'(vq[k].valid));
      chk($sformatf("v%0d id_pc", k), id_pc, vq[k].pc);
      chk($sformatf("v%0d id_instr", k), id_instr, vq[k].valid ? mem_word(vq[k].pc) : NOP);
      chk($sformatf("v%0d misalign", k), 32'(misalign), 32'(vq[k].mis));
      if (k == 2) chk("dut2 wrapped imem_addr", imem_addr2, 32'h0);
      if (id_valid2 && exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk($sformatf("v%0d dut2 id_pc", k), id_pc2, e);
        chk($sformatf("v%0d dut2 id_instr", k), id_instr2, mem_word(e));
      end
    end
    chk("dut2 sequence drained", 32'(exp_q.size()), 32'h0);

    // Stall with a word queued and a fetch in flight, then reset mid-cycle.
    next_cycle();
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    @(negedge clk);
    chk("pre-rst id_valid", 32'(id_valid), 32'h1);
    chk("pre-rst id_pc", id_pc, 32'h204);
    chk("pre-rst imem_req", 32'(imem_req), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("async rst pc_current_r", pc_current_r, 32'h0);
    chk("async rst imem_req", 32'(imem_req), 32'h0);
    chk("async rst id_valid", 32'(id_valid), 32'h0);
    chk("async rst id_instr", id_instr, NOP);
    chk("async rst id_pc", id_pc, 32'h0);
    chk("async rst misalign", 32'(misalign), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    chk("restart r0 imem_req", 32'(imem_req), 32'h1);
    chk("restart r0 imem_addr", imem_addr, 32'h0);
    chk("restart r0 id_valid", 32'(id_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("restart r1 id_valid", 32'(id_valid), 32'h0);
    chk("restart r1 imem_addr", imem_addr, 32'h4);
    next_cycle();
    @(negedge clk);
    chk("restart r2 id_valid", 32'(id_valid), 32'h1);
    chk("restart r2 id_pc", id_pc, 32'h0);
    chk("restart r2 id_instr", id_instr, mem_word(32'h0));
    chk("restart r2 dut2 id_pc", id_pc2, RESET_PC2);
    next_cycle();
    @(negedge clk);
    chk("restart r3 id_pc", id_pc, 32'h4);
    chk("restart r3 id_instr", id_instr, mem_word(32'h4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
